// File: rtl/elevator_car_ctrl.sv
// Single-car elevator sequencer: latches floor requests into a pending bitmap,
// serves them SCAN-style, one floor per TRAVEL_CYCLES, door dwell DOOR_CYCLES.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = 16,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  output logic               req_err,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               up,
  output logic               down,
  output logic               door_open,
  output logic               busy,
  output logic [15:0]        floor_transition_counter
);

  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic                    dir_up_reg, dir_up_next;
  logic [NUM_FLOORS-1:0]   pending_reg, pending_next;
  logic [TRAVEL_W-1:0]     travel_cnt_reg, travel_cnt_next;
  logic [DOOR_W-1:0]       dwell_cnt_reg, dwell_cnt_next;
  logic [FLOOR_W-1:0]      floor_reg, floor_next;
  logic [15:0]             trans_cnt_reg, trans_cnt_next;
  logic                    req_ready_reg;
  logic                    req_err_reg, req_err_next;
  logic                    up_reg, up_next;
  logic                    down_reg, down_next;
  logic                    door_reg, door_next;
  logic                    busy_reg, busy_next;

  logic                    accept;
  logic                    in_range;
  logic                    req_ok;
  logic                    req_here;
  logic [FLOOR_W-1:0]      move_floor;
  logic [NUM_FLOORS-1:0]   req_set;
  logic [NUM_FLOORS-1:0]   req_set_far;
  logic [NUM_FLOORS-1:0]   here_onehot;
  logic [NUM_FLOORS-1:0]   arrive_onehot;
  logic [NUM_FLOORS-1:0]   pend_above;
  logic [NUM_FLOORS-1:0]   pend_below;

  assign accept     = req_valid && req_ready_reg;
  assign in_range   = (req_floor < FLOOR_W'(NUM_FLOORS));
  assign req_ok     = accept && in_range;
  assign req_here   = req_ok && (req_floor == floor_reg);
  assign move_floor = dir_up_reg ? (floor_reg + FLOOR_W'(1)) : (floor_reg - FLOOR_W'(1));

  // Per-floor decode: request mask, position masks and "ahead" masks for SCAN.
  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      assign req_set[gi]       = req_ok && (req_floor == FLOOR_W'(gi));
      assign here_onehot[gi]   = (floor_reg == FLOOR_W'(gi));
      assign arrive_onehot[gi] = (move_floor == FLOOR_W'(gi));
      assign pend_above[gi]    = pending_reg[gi] && (FLOOR_W'(gi) > floor_reg);
      assign pend_below[gi]    = pending_reg[gi] && (FLOOR_W'(gi) < floor_reg);
    end
  endgenerate

  // A same-floor request never becomes a pending bit while the car is parked here.
  assign req_set_far = req_set & ~here_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      dir_up_reg     <= 1'b1;
      pending_reg    <= '0;
      travel_cnt_reg <= '0;
      dwell_cnt_reg  <= '0;
      floor_reg      <= '0;
      trans_cnt_reg  <= '0;
      req_ready_reg  <= 1'b0;
      req_err_reg    <= 1'b0;
      up_reg         <= 1'b0;
      down_reg       <= 1'b0;
      door_reg       <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dir_up_reg     <= dir_up_next;
      pending_reg    <= pending_next;
      travel_cnt_reg <= travel_cnt_next;
      dwell_cnt_reg  <= dwell_cnt_next;
      floor_reg      <= floor_next;
      trans_cnt_reg  <= trans_cnt_next;
      req_ready_reg  <= 1'b1;
      req_err_reg    <= req_err_next;
      up_reg         <= up_next;
      down_reg       <= down_next;
      door_reg       <= door_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    dir_up_next     = dir_up_reg;
    pending_next    = pending_reg;
    travel_cnt_next = travel_cnt_reg;
    dwell_cnt_next  = dwell_cnt_reg;
    floor_next      = floor_reg;
    trans_cnt_next  = trans_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (|(pending_reg & here_onehot)) begin
          pending_next   = (pending_reg & ~here_onehot) | req_set_far;
          state_next     = S_DOOR;
          dwell_cnt_next = '0;
        end else if (|pending_reg) begin
          // Leaving edge: a request for this floor is kept for a later visit.
          pending_next    = pending_reg | req_set;
          state_next      = S_MOVE;
          travel_cnt_next = '0;
          if (dir_up_reg ? !(|pend_above) : !(|pend_below)) begin
            dir_up_next = !dir_up_reg;
          end
        end else if (req_here) begin
          state_next     = S_DOOR;
          dwell_cnt_next = '0;
        end else begin
          pending_next = pending_reg | req_set;
        end
      end
      S_MOVE: begin
        pending_next = pending_reg | req_set;
        if (travel_cnt_reg == TRAVEL_LAST) begin
          floor_next     = move_floor;
          trans_cnt_next = trans_cnt_reg + 16'd1;
          if (|(pending_next & arrive_onehot)) begin
            pending_next   = pending_next & ~arrive_onehot;
            state_next     = S_DOOR;
            dwell_cnt_next = '0;
          end else begin
            travel_cnt_next = '0;
          end
        end else begin
          travel_cnt_next = travel_cnt_reg + TRAVEL_W'(1);
        end
      end
      S_DOOR: begin
        pending_next = pending_reg | req_set_far;
        if (door_hold || req_here) begin
          dwell_cnt_next = '0;
        end else if (dwell_cnt_reg == DOOR_LAST) begin
          state_next = S_IDLE;
        end else begin
          dwell_cnt_next = dwell_cnt_reg + DOOR_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    up_next      = 1'b0;
    down_next    = 1'b0;
    door_next    = 1'b0;
    if (state_next == S_MOVE) begin
      up_next   = dir_up_next;
      down_next = !dir_up_next;
    end
    if (state_next == S_DOOR) begin
      door_next = 1'b1;
    end
    busy_next    = (state_next != S_IDLE) || (|pending_next);
    req_err_next = accept && !in_range;
  end

  assign req_ready                = req_ready_reg;
  assign req_err                  = req_err_reg;
  assign current_floor            = floor_reg;
  assign up                       = up_reg;
  assign down                     = down_reg;
  assign door_open                = door_reg;
  assign busy                     = busy_reg;
  assign floor_transition_counter = trans_cnt_reg;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl: a countdown-timer model of the car checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_elevator_car_ctrl;

  localparam int NF = 16;
  localparam int FW = 16;
  localparam int TC = 8;
  localparam int DC = 16;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          door_hold = 1'b0;
  logic          req_ready;
  logic          req_err;
  logic [FW-1:0] current_floor;
  logic          up;
  logic          down;
  logic          door_open;
  logic          busy;
  logic [15:0]   floor_transition_counter;

  int checks = 0;
  int errors = 0;
  logic [31:0] stop_code;

  always #5 clk = ~clk;

  elevator_car_ctrl #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .req_err(req_err),
    .door_hold(door_hold),
    .current_floor(current_floor), .up(up), .down(down),
    .door_open(door_open), .busy(busy),
    .floor_transition_counter(floor_transition_counter)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the car is parked, travelling, or holding the door, with
  // countdowns of edges left until the next arrival / door close.
  bit          m_active = 1'b0;
  int          m_mode, m_floor, m_travel_left, m_door_left;
  bit          m_dir_up, m_err, m_ready;
  bit [NF-1:0] m_pend;
  logic [15:0] m_trans;

  always @(posedge clk) begin : model
    bit acc, ok, ahead;
    int rf, nf;
    if (rst) begin
      m_active = 1'b1; m_mode = M_IDLE; m_floor = 0; m_dir_up = 1'b1;
      m_pend = '0; m_trans = '0; m_err = 1'b0; m_ready = 1'b0;
      m_travel_left = 0; m_door_left = 0;
    end else if (m_active) begin
      acc = req_valid && m_ready;
      m_err = acc && (int'(req_floor) >= NF);
      ok = acc && !m_err;
      rf = int'(req_floor);
      m_ready = 1'b1;
      case (m_mode)
        M_IDLE: begin
          if (m_pend[m_floor]) begin
            m_pend[m_floor] = 1'b0;
            if (ok && rf != m_floor) m_pend[rf] = 1'b1;
            m_mode = M_DOOR; m_door_left = DC;
          end else if (m_pend != 0) begin
            ahead = 1'b0;
            for (int f = 0; f < NF; f++)
              if (m_pend[f] && (m_dir_up ? (f > m_floor) : (f < m_floor))) ahead = 1'b1;
            if (!ahead) m_dir_up = !m_dir_up;
            if (ok) m_pend[rf] = 1'b1;
            m_mode = M_MOVE; m_travel_left = TC;
          end else if (ok && rf == m_floor) begin
            m_mode = M_DOOR; m_door_left = DC;
          end else if (ok) begin
            m_pend[rf] = 1'b1;
          end
        end
        M_MOVE: begin
          if (ok) m_pend[rf] = 1'b1;
          m_travel_left--;
          if (m_travel_left == 0) begin
            nf = m_dir_up ? m_floor + 1 : m_floor - 1;
            m_floor = nf;
            m_trans = m_trans + 16'd1;
            if (m_pend[nf]) begin
              m_pend[nf] = 1'b0;
              m_mode = M_DOOR; m_door_left = DC;
            end else begin
              m_travel_left = TC;
            end
          end
        end
        default: begin
          if (ok && rf != m_floor) m_pend[rf] = 1'b1;
          if (door_hold || (ok && rf == m_floor)) begin
            m_door_left = DC;
          end else begin
            m_door_left--;
            if (m_door_left == 0) m_mode = M_IDLE;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_active) begin
      chk("req_ready", req_ready, m_ready);
      chk("req_err", req_err, m_err);
      chk("current_floor", current_floor, m_floor);
      chk("up", up, (m_mode == M_MOVE) && m_dir_up);
      chk("down", down, (m_mode == M_MOVE) && !m_dir_up);
      chk("door_open", door_open, m_mode == M_DOOR);
      chk("busy", busy, (m_mode != M_IDLE) || (m_pend != 0));
      chk("floor_transition_counter", floor_transition_counter, m_trans);
    end
  end

  task automatic send(input int f);
    req_valid = 1'b1;
    req_floor = FW'(f);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for busy to drop, recording each floor where the door opens.
  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    logic prev = door_open;
    while (busy !== 1'b0) begin
      @(negedge clk);
      n++;
      if (door_open === 1'b1 && prev !== 1'b1) stop_code = (stop_code << 4) | 32'(current_floor);
      prev = door_open;
      if (n >= budget) begin
        checks++; errors++;
        $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        break;
      end
    end
  endtask

  task automatic wait_floor(input string name, input int f, input int budget);
    int n = 0;
    while (current_floor !== FW'(f) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: floor=%0d, required %0d", name, current_floor, f);
    end
  endtask

  initial begin
    int n, open_cycles;
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_up", up, 0);
    chk("rst_door", door_open, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_floor", current_floor, 0);
    repeat (3) @(negedge clk);

    // Floor 0 -> 3: up at E1, arrival at E1+24, door 16 cycles
    send(3);
    chk("t2_e0_up", up, 0);
    chk("t2_e0_busy", busy, 1);
    @(negedge clk);
    chk("t2_e1_up", up, 1);
    repeat (23) @(negedge clk);
    chk("t2_e23_floor", current_floor, 2);
    @(negedge clk);
    chk("t2_arrive_floor", current_floor, 3);
    chk("t2_arrive_door", door_open, 1);
    chk("t2_arrive_up", up, 0);
    chk("t2_counter", floor_transition_counter, 3);
    repeat (15) @(negedge clk);
    chk("t2_door_last", door_open, 1);
    @(negedge clk);
    chk("t2_door_closed", door_open, 0);
    chk("t2_busy_done", busy, 0);

    // From 3 toward 9, inject 7 and 2 at floor 5
    stop_code = 1;
    send(9);
    wait_floor("t3_reach5", 5, 200);
    send(7);
    send(2);
    wait_idle("t3", 2000);
    chk("t3_stops", stop_code, 32'h1792);
    chk("t3_counter", floor_transition_counter, 16);
    chk("t3_floor", current_floor, 2);

    // Request 6 on the arrival edge at floor 6 while passing toward 8
    send(8);
    n = 0;
    while (!(m_mode == M_MOVE && m_floor == 5 && m_travel_left == 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_floor = FW'(6);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t4_stop_floor", current_floor, 6);
    chk("t4_stop_door", door_open, 1);
    stop_code = 32'h16;
    wait_idle("t4", 2000);
    chk("t4_stops", stop_code, 32'h168);
    chk("t4_counter", floor_transition_counter, 22);

    // Request for the floor being left is served later
    stop_code = 1;
    send(3);
    send(8);
    chk("t4b_down", down, 1);
    wait_idle("t4b", 2000);
    chk("t4b_stops", stop_code, 32'h138);
    chk("t4b_counter", floor_transition_counter, 32);

    // Out-of-range requests
    send(20);
    chk("t5_err", req_err, 1);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    chk("t5_err_pulse", req_err, 0);
    send(16);
    chk("t5_err16", req_err, 1);
    @(negedge clk);

    // Both ends of the shaft
    stop_code = 1;
    send(15);
    send(0);
    wait_idle("t5b", 3000);
    chk("t5b_stops", stop_code, 32'h1F0);
    chk("t5b_counter", floor_transition_counter, 54);

    // Same-floor request while idle opens the door without moving
    send(0);
    chk("same_floor_door", door_open, 1);
    chk("same_floor_up", up, 0);
    wait_idle("same_floor", 200);
    chk("same_floor_counter", floor_transition_counter, 54);

    // door_hold for 40 cycles at floor 4
    send(4);
    n = 0;
    while (door_open !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    open_cycles = 1;
    door_hold = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (door_open === 1'b1) open_cycles++;
    end
    door_hold = 1'b0;
    n = 0;
    while (door_open === 1'b1 && n < 200) begin
      @(negedge clk);
      if (door_open === 1'b1) open_cycles++;
      n++;
    end
    chk("t6_open_cycles", open_cycles, 56);
    chk("t6_counter", floor_transition_counter, 58);

    // Reset mid-MOVE
    send(9);
    wait_floor("t6_reach6", 6, 200);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_floor", current_floor, 0);
    chk("t6_rst_up", up, 0);
    chk("t6_rst_down", down, 0);
    chk("t6_rst_door", door_open, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_counter", floor_transition_counter, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_ready", req_ready, 1);
    repeat (4) @(negedge clk);
    chk("t6_post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
